// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
// Imported by the controller and by anything driving its Sub input.
package cla_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cla_nibble_sequencer.sv
// Multi-precision add/subtract that time-shares one external 4-bit CLA slice,
// feeding one nibble per cycle LSB first with the carry held between cycles.
module cla_nibble_sequencer
   import cla_seq_pkg::*;
#(
   parameter int NIB = 4
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             Sub,
   input  logic [4*NIB-1:0] A,
   input  logic [4*NIB-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [4*NIB-1:0] Sum,
   output logic             Cout,
   output logic             Ovf,
   output logic [3:0]       Slice_A,
   output logic [3:0]       Slice_B,
   output logic             Slice_Cin,
   input  logic [3:0]       Slice_S,
   input  logic             Slice_Cout
);

   localparam int W  = 4 * NIB;
   localparam int IW = $clog2(NIB);
   localparam logic [IW-1:0] LAST = IW'(NIB - 1);

   state_t         state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic           sub_q, sub_d;
   logic           carry_q, carry_d;
   logic [W-1:0]   sum_q, sum_d;
   logic           cout_q, cout_d;
   logic           ovf_q, ovf_d;

   logic           inv;
   logic           bx_msb;

   // Operand B is inverted per nibble for subtraction; carry-in supplies the +1.
   assign inv    = (sub_q == OP_SUB);
   assign bx_msb = b_q[W-1] ^ inv;

   // Slice drive, next-state and result update; slice inputs idle at zero.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      a_d       = a_q;
      b_d       = b_q;
      sub_d     = sub_q;
      carry_d   = carry_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      ovf_d     = ovf_q;
      Slice_A   = 4'h0;
      Slice_B   = 4'h0;
      Slice_Cin = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (Start) begin
               a_d     = A;
               b_d     = B;
               sub_d   = Sub;
               carry_d = Sub;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            Slice_A   = a_q[{idx_q, 2'b00} +: 4];
            Slice_B   = b_q[{idx_q, 2'b00} +: 4] ^ {4{inv}};
            Slice_Cin = carry_q;
            sum_d[{idx_q, 2'b00} +: 4] = Slice_S;
            carry_d = Slice_Cout;
            if (idx_q == LAST) begin
               cout_d  = Slice_Cout;
               ovf_d   = (a_q[W-1] ^ Slice_S[3]) & (bx_msb ^ Slice_S[3]);
               state_d = DONE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial result.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sub_q   <= sub_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign Busy = (state_q != IDLE);
   assign Done = (state_q == DONE);
   assign Sum  = sum_q;
   assign Cout = cout_q;
   assign Ovf  = ovf_q;

endmodule
